// File: rtl/uart_num_parser.sv
// uart_num_parser: turns the UART receiver byte stream into decimal tokens behind a one-entry valid/ready buffer.
// Optional feature: define UART_NUM_PARSER_NEG_EN to accept a leading '-' and emit two's-complement values.
// state | meaning
// SKIP  | between numbers, waiting for a digit
// ACCUM | accumulating the digits of one number
// DONE  | EOT seen, every byte ignored until clear
module uart_num_parser #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [7:0]       rx_byte,
  input  logic             rx_valid,
  input  logic             clear,
  output logic [WIDTH-1:0] num_value,
  output logic             num_eol,
  output logic             num_blank,
  output logic             num_last,
  output logic             num_valid,
  input  logic             num_ready,
  output logic             overflow,
  output logic             overrun
);

  localparam int XW = WIDTH + 4;
`ifdef UART_NUM_PARSER_NEG_EN
  localparam bit             NEG_EN = 1'b1;
  localparam logic [XW-1:0]  LIMIT  = {5'b0, {(WIDTH-1){1'b1}}};
`else
  localparam bit             NEG_EN = 1'b0;
  localparam logic [XW-1:0]  LIMIT  = {4'b0, {WIDTH{1'b1}}};
`endif

  typedef enum logic [1:0] {SKIP, ACCUM, DONE} state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_acc;
  logic             r_line_has_num;
  logic             r_neg;
  logic             r_has_digit;

  logic             w_is_digit, w_is_lf, w_is_eot, w_is_cr, w_is_minus, w_take;
  logic [3:0]       w_digit;
  logic [XW-1:0]    w_mac;
  logic             w_sat;
  logic [WIDTH-1:0] w_acc_next;
  logic [WIDTH-1:0] w_signed_val;
  logic             w_emit, w_tok_eol, w_tok_blank, w_tok_last;
  logic [WIDTH-1:0] w_tok_value;

  assign w_is_digit = (rx_byte >= 8'h30) && (rx_byte <= 8'h39);
  assign w_is_lf    = (rx_byte == 8'h0A);
  assign w_is_eot   = (rx_byte == 8'h04);
  assign w_is_cr    = (rx_byte == 8'h0D);
  assign w_is_minus = (rx_byte == 8'h2D);
  assign w_digit    = rx_byte[3:0];
  assign w_take     = rx_valid && !w_is_cr;

  // Wide enough that acc*10+9 never wraps, so the compare against LIMIT is exact.
  assign w_mac        = {4'b0, r_acc} * XW'(10) + XW'(w_digit);
  assign w_sat        = (w_mac > LIMIT);
  assign w_acc_next   = w_sat ? LIMIT[WIDTH-1:0] : w_mac[WIDTH-1:0];
  assign w_signed_val = r_neg ? ('0 - r_acc) : r_acc;

  always_comb begin
    w_emit      = 1'b0;
    w_tok_value = '0;
    w_tok_eol   = 1'b0;
    w_tok_blank = 1'b0;
    w_tok_last  = 1'b0;
    if (w_take) begin
      case (r_state)
        SKIP: begin
          if (w_is_lf && !r_line_has_num) begin
            w_emit      = 1'b1;
            w_tok_blank = 1'b1;
          end else if (w_is_eot) begin
            w_emit      = 1'b1;
            w_tok_blank = 1'b1;
            w_tok_last  = 1'b1;
          end
        end
        ACCUM: begin
          // A lone '-' has no digits and therefore produces no token.
          if (!w_is_digit && r_has_digit) begin
            w_emit      = 1'b1;
            w_tok_value = w_signed_val;
            w_tok_eol   = w_is_lf || w_is_eot;
            w_tok_last  = w_is_eot;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state        <= SKIP;
      r_acc          <= '0;
      r_line_has_num <= 1'b0;
      r_neg          <= 1'b0;
      r_has_digit    <= 1'b0;
      num_value      <= '0;
      num_eol        <= 1'b0;
      num_blank      <= 1'b0;
      num_last       <= 1'b0;
      num_valid      <= 1'b0;
      overflow       <= 1'b0;
      overrun        <= 1'b0;
    end else if (clear) begin
      r_state        <= SKIP;
      r_acc          <= '0;
      r_line_has_num <= 1'b0;
      r_neg          <= 1'b0;
      r_has_digit    <= 1'b0;
      num_value      <= '0;
      num_eol        <= 1'b0;
      num_blank      <= 1'b0;
      num_last       <= 1'b0;
      num_valid      <= 1'b0;
      overflow       <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (num_valid && num_ready)
        num_valid <= 1'b0;
      if (w_emit) begin
        if (!num_valid || num_ready) begin
          num_value <= w_tok_value;
          num_eol   <= w_tok_eol;
          num_blank <= w_tok_blank;
          num_last  <= w_tok_last;
          num_valid <= 1'b1;
        end else begin
          overrun <= 1'b1;
        end
      end

      if (w_take) begin
        case (r_state)
          SKIP: begin
            if (w_is_digit) begin
              r_acc       <= WIDTH'(w_digit);
              r_has_digit <= 1'b1;
              r_neg       <= 1'b0;
              r_state     <= ACCUM;
            end else if (NEG_EN && w_is_minus) begin
              r_acc       <= '0;
              r_has_digit <= 1'b0;
              r_neg       <= 1'b1;
              r_state     <= ACCUM;
            end else if (w_is_lf) begin
              r_line_has_num <= 1'b0;
            end else if (w_is_eot) begin
              r_state <= DONE;
            end
          end
          ACCUM: begin
            if (w_is_digit) begin
              r_acc       <= w_acc_next;
              r_has_digit <= 1'b1;
              if (w_sat)
                overflow <= 1'b1;
            end else begin
              r_acc <= '0;
              if (w_is_lf)
                r_line_has_num <= 1'b0;
              else if (!w_is_eot && r_has_digit)
                r_line_has_num <= 1'b1;
              r_state <= w_is_eot ? DONE : SKIP;
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule
